// File: rtl/program_loader.sv
// Instruction-store writer: pairs streamed func/value nibbles into a 16-entry RAM
// and serves the CPU fetch port, which reads as NOP while a load is running.
module program_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] pos,
  output logic [DW-1:0] func,
  output logic [DW-1:0] value,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_FUNC,
    GET_VALUE,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   addr;
  logic [CW-1:0]   count;
  logic [DW-1:0]   func_q;
  logic [DW-1:0]   value_q;
  logic [2*DW-1:0] mem [DEPTH];

  logic load_c;
  logic take_func_c;
  logic take_value_c;
  logic write_c;
  logic last_c;

  // Entry being written is the final one when addr+1 reaches the count.
  assign last_c = (CW'(addr) + CW'(1)) == count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    load_c       = 1'b0;
    take_func_c  = 1'b0;
    take_value_c = 1'b0;
    write_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c   = 1'b1;
          state_nx = GET_FUNC;
        end
      end
      GET_FUNC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          take_func_c = 1'b1;
          state_nx    = GET_VALUE;
        end
      end
      GET_VALUE: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          take_value_c = 1'b1;
          state_nx     = WRITE;
        end
      end
      WRITE: begin
        busy     = 1'b1;
        write_c  = 1'b1;
        state_nx = last_c ? DONE : GET_FUNC;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load_c   = 1'b1;
          state_nx = GET_FUNC;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: count/address, nibble latches and the RAM itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= '0;
      count   <= '0;
      func_q  <= '0;
      value_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (load_c) begin
        count <= (len == '0) ? CW'(DEPTH) : CW'(len);
        addr  <= '0;
      end
      if (take_func_c)  func_q  <= in_data;
      if (take_value_c) value_q <= in_data;
      if (write_c) begin
        mem[addr] <= {func_q, value_q};
        if (!last_c) addr <= addr + AW'(1);
      end
    end
  end

  assign func  = busy ? '0 : mem[pos][2*DW-1:DW];
  assign value = busy ? '0 : mem[pos][DW-1:0];

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and randomized loads checked against a
// behavioural RAM image that is updated whole-load at a time.
module tb_program_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] pos;
  logic [3:0] func;
  logic [3:0] value;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  logic [3:0] model_f [16];
  logic [3:0] model_v [16];
  logic [3:0] ld_f [16];
  logic [3:0] ld_v [16];
  logic       rdy_trace [$];

  program_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pos      (pos),
    .func     (func),
    .value    (value),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    for (int p = 0; p < 16; p++) begin
      pos = 4'(p);
      #1;
      check($sformatf("%s_func%0d", tag, p), 32'(func), 32'(model_f[p]));
      check($sformatf("%s_value%0d", tag, p), 32'(value), 32'(model_v[p]));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      model_f[i] = '0;
      model_v[i] = '0;
    end
  endtask

  task automatic random_stream();
    for (int i = 0; i < 16; i++) begin
      ld_f[i] = 4'($urandom);
      ld_v[i] = 4'($urandom);
    end
  endtask

  // Runs one complete load of n instructions from ld_f/ld_v.
  // gap_mode: 0 valid held high, 1 valid pattern 1,0,0, 2 random valid.
  task automatic do_load(input string tag, input int n, input int gap_mode, input bit inject_start);
    int beat;
    int cyc;
    int last_edge;
    bit injected;
    bit xfer;
    rdy_trace.delete();
    start    = 1'b1;
    len      = 4'(n);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    len       = 4'($urandom);
    beat      = 0;
    cyc       = 0;
    last_edge = -100;
    injected  = 1'b0;
    while (done !== 1'b1 && cyc < 400) begin
      check({tag, "_busy"}, 32'(busy), 32'(1));
      pos = 4'($urandom);
      #1;
      check({tag, "_nop_func"}, 32'(func), 32'(0));
      check({tag, "_nop_value"}, 32'(value), 32'(0));
      rdy_trace.push_back(in_ready);
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 3) == 0;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      if (beat >= 2 * n) in_valid = 1'b0;
      else in_data = (beat % 2 == 0) ? ld_f[beat / 2] : ld_v[beat / 2];
      if (inject_start && !injected && (beat % 2 == 1)) begin
        start    = 1'b1;
        len      = 4'($urandom);
        injected = 1'b1;
      end
      xfer = in_valid && in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (xfer) begin
        beat++;
        if (beat == 2 * n) last_edge = cyc;
      end
    end
    in_valid = 1'b0;
    check({tag, "_done"}, 32'(done), 32'(1));
    check({tag, "_busy_end"}, 32'(busy), 32'(0));
    check({tag, "_ready_end"}, 32'(in_ready), 32'(0));
    check({tag, "_beats"}, 32'(beat), 32'(2 * n));
    check({tag, "_done_latency"}, 32'(cyc - last_edge), 32'(1));
    for (int i = 0; i < n; i++) begin
      model_f[i] = ld_f[i];
      model_v[i] = ld_v[i];
    end
  endtask

  task automatic check_ready_pattern(input string tag, input int n);
    check({tag, "_trace_len"}, 32'(rdy_trace.size()), 32'(3 * n));
    for (int i = 0; i < rdy_trace.size() && i < 3 * n; i++)
      check($sformatf("%s_ready%0d", tag, i), 32'(rdy_trace[i]), 32'((i % 3) != 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", total);
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    len      = '0;
    in_data  = '0;
    in_valid = 1'b0;
    pos      = '0;
    clear_model();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(in_ready), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done", 32'(done), 32'(0));
    check_all("reset");

    // Basic load: len=2, stream 3,5,1,7
    ld_f[0] = 4'd3; ld_v[0] = 4'd5;
    ld_f[1] = 4'd1; ld_v[1] = 4'd7;
    do_load("basic", 2, 0, 1'b0);
    check_ready_pattern("basic", 2);
    check_all("basic");

    // Same stream with gaps on in_valid
    clear_model();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_f[0] = 4'd3; model_v[0] = 4'd5;
    model_f[1] = 4'd1; model_v[1] = 4'd7;
    clear_model();
    do_load("gaps", 2, 1, 1'b0);
    check_all("gaps");

    // Full depth via len=0
    for (int i = 0; i < 16; i++) begin
      ld_f[i] = 4'(i);
      ld_v[i] = 4'(15 - i);
    end
    do_load("full", 16, 0, 1'b0);
    check_ready_pattern("full", 16);
    check_all("full");

    // start pulse during GET_VALUE is ignored
    random_stream();
    do_load("ignstart", 5, 2, 1'b1);
    check_all("ignstart");

    // Reset mid-load after entry 1 has been written
    start    = 1'b1;
    len      = 4'd4;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 4'($urandom);
      @(posedge clk);
      #1;
    end
    check("abort_busy_before", 32'(busy), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(in_ready), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    clear_model();
    check_all("abort");

    // Reload len=1 over a full random image
    random_stream();
    do_load("prefill", 16, 2, 1'b0);
    ld_f[0] = 4'd9;
    ld_v[0] = 4'd4;
    do_load("reload", 1, 0, 1'b0);
    check_all("reload");

    // Randomized loads
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 16);
      random_stream();
      do_load($sformatf("rand%0d", r), n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      check_all($sformatf("rand%0d", r));
    end

    // Reset while in DONE clears done immediately
    check("done_before_rst", 32'(done), 32'(1));
    #3;
    rst = 1'b1;
    #1;
    check("rst_in_done", 32'(done), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    check_all("final_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU's instruction store: 16-entry program RAM of {func, value} nibble pairs.
- Accepts a nibble stream over a valid/ready handshake from a host or debug port, pairs each func nibble with the value nibble that follows it, and writes the pair at a sequential address.
- The CPU fetches from the asynchronous read port using its program counter (pos).
- While a load is in progress the read port returns NOP (func=0, value=0).

Parameters:
- DEPTH, 16, number of instruction entries (must equal 2**AW).
- AW, 4, address width; matches CPU pos width.
- DW, 4, width of the func field and of the value field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  1-cycle pulse; begins a load when idle or done.
- len  input  AW  number of instructions to load, sampled on start; 0 means DEPTH.
- in_data  input  DW  stream nibble: func on even beats, value on odd beats.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a beat this cycle.
- pos  input  AW  CPU fetch address.
- func  output  DW  opcode at pos.
- value  output  DW  operand at pos.
- busy  output  1  load in progress.
- done  output  1  last load completed; held until the next start or reset.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE; all 16 RAM entries clear to 0; address counter, count register and nibble latches clear to 0.
  - in_ready=0, busy=0, done=0.
  - Reset mid-load aborts the load; no partial entry survives.
- Beat transfer: occurs on a rising clk edge with in_valid=1 and in_ready=1. in_ready is registered-state decode only and never depends on in_valid.
- States and transitions:
  - IDLE: in_ready=0. start=1 → latch len into the count register, addr←0, done←0, go to GET_FUNC.
  - GET_FUNC: in_ready=1, busy=1. On transfer, latch in_data as func and go to GET_VALUE.
  - GET_VALUE: in_ready=1, busy=1. On transfer, latch in_data as value and go to WRITE.
  - WRITE: in_ready=0, busy=1.
    - RAM[addr]←{func_latch, value_latch}.
    - If the entries written so far (including this one) equal the count (0 means 16): go to DONE.
    - Otherwise addr←addr+1 and go to GET_FUNC.
  - DONE: busy=0, done=1, in_ready=0. start=1 → same action as from IDLE.
- start is ignored in GET_FUNC, GET_VALUE and WRITE. len is ignored except in the cycle start is accepted.
- Throughput: 3 cycles per instruction minimum with in_valid held high. done rises on the clk edge after the final WRITE cycle.
- Address rules:
  - Writes go to 0..count-1 in order.
  - With len=0, the 16th write lands at address 15 and addr does not wrap.
  - Entries beyond the loaded count keep their previous contents; a reload overwrites only 0..count-1.
- Read port:
  - Combinational: func/value = RAM[pos] when busy=0, and 0/0 when busy=1.
  - A write in WRITE is visible on the read port after that clk edge.
- Arithmetic: the entry counter is AW+1 bits internally, so a count of 16 compares without overflow.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → in_ready=0, busy=0, done=0 immediately; func=0, value=0 for pos=0..15.
- Basic load:
  - Stimulus: start with len=2; stream 3,5,1,7 with in_valid held high.
  - Required: in_ready high 2 cycles, low 1, high 2, low 1; done=1 one cycle after the second WRITE.
  - Required read values: pos=0 → func=3/value=5; pos=1 → 1/7; pos=2 → 0/0.
- Gaps: same stream with in_valid toggling 1,0,0,1,... → no beat lost or duplicated; final contents identical to the basic load.
- Full depth: start with len=0; stream 32 nibbles where entry i has func=i, value=15-i → pos=15 reads func=15, value=0; done=1; no write to address 0 after the wrap point.
- Busy/abort:
  - start pulse during GET_VALUE → ignored; load completes normally.
  - New load: rst pulse after entry 1 written → IDLE, entries 0–1 read 0/0, done=0.
- Reload: after done, start with len=1 and stream 9,4 → func/value read 0/0 while busy; afterwards pos=0 reads 9/4 and pos=1 retains its old entry.
